// File: rtl/ldtu_gsb_pkg.sv
// ldtu_gsb_pkg
// Shared definitions for the dual-gain look-ahead buffer:
//   gsm_e         - GAIN_SEL_MODE encodings
//   *_DEF         - default widths/depths used by the top level
//   SAT_RESET     - reset value of the saturation threshold register (all ones,
//                   sliced to DATA_W by the user)
package ldtu_gsb_pkg;

    typedef enum logic [1:0] {
        GSM_AUTO    = 2'b00,  // auto select, window = win_len
        GSM_AUTO2   = 2'b01,  // auto select, window = 2 * win_len
        GSM_FORCE10 = 2'b10,  // always forward gain x10
        GSM_FORCE1  = 2'b11   // always forward gain x1
    } gsm_e;

    localparam int DATA_W_DEF    = 12;
    localparam int DEPTH_DEF     = 16;
    localparam int WIN_W_DEF     = 6;
    localparam int BASE_BITS_DEF = 6;

    localparam logic [31:0] SAT_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/ldtu_lookahead_ram.sv
// ldtu_lookahead_ram
// Dual-gain circular storage: one write port, one registered indexed read.
// Ports:
//   CLK, reset              clock, async active-high reset (read regs only)
//   we_i, waddr_i           write enable / address
//   wdata10_i, wdata01_i    gain-x10 / gain-x1 sample to store
//   re_i, raddr_i           read enable / address
//   rdata10_o, rdata01_o    registered read data, held while re_i is low
module ldtu_lookahead_ram
    import ldtu_gsb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata10_i,
    input  logic [DATA_W-1:0] wdata01_i,
    input  logic              re_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata10_o,
    output logic [DATA_W-1:0] rdata01_o
);

    logic [DATA_W-1:0] mem10_q [DEPTH];
    logic [DATA_W-1:0] mem01_q [DEPTH];
    logic [DATA_W-1:0] rd10_q, rd01_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem10_q[waddr_i] <= wdata10_i;
            mem01_q[waddr_i] <= wdata01_i;
        end
    end

    // With zero look-ahead the read index equals the write index, so the
    // sample arriving this cycle is forwarded straight into the read register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd10_q <= '0;
            rd01_q <= '0;
        end else if (re_i) begin
            if (we_i && (raddr_i == waddr_i)) begin
                rd10_q <= wdata10_i;
                rd01_q <= wdata01_i;
            end else begin
                rd10_q <= mem10_q[raddr_i];
                rd01_q <= mem01_q[raddr_i];
            end
        end
    end

    assign rdata10_o = rd10_q;
    assign rdata01_o = rd01_q;

endmodule

// File: rtl/ldtu_gain_select_buffer.sv
// ldtu_gain_select_buffer
// Look-ahead dual-gain buffer with per-sample gain selection. Sample n written
// now emits sample n-L one cycle later; the gain choice for that sample looks
// at saturation of the gain-x10 stream over the last W writes ending at n.
// Ports:
//   CLK, reset            clock, async active-high reset
//   in_valid              accept one sample pair this cycle
//   DATA_gain_10/_01      gain-x10 / gain-x1 samples
//   SATURATION_value      x10 saturation threshold (registered)
//   GAIN_SEL_MODE         00 auto, 01 auto x2 window, 10 force x10, 11 force x1
//   win_len               window length, 0 behaves as 1 (registered)
//   ref_offset            look-ahead L, captured after reset and on flush
//   flush                 clear fill state, discards a coincident sample
//   out_valid             out_data/baseline_flag valid
//   out_data              {gain bit (1 = x1), sample}
//   baseline_flag         emitted sample is baseline
//   sat_count             saturation-window starts
// Optional feature macro: GAIN_SEL_STATS_EN enables the sat_count counter;
// otherwise sat_count is tied to zero.
module ldtu_gain_select_buffer
    import ldtu_gsb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int WIN_W     = WIN_W_DEF,
    parameter int BASE_BITS = BASE_BITS_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] DATA_gain_10,
    input  logic [DATA_W-1:0] DATA_gain_01,
    input  logic [DATA_W-1:0] SATURATION_value,
    input  logic [1:0]        GAIN_SEL_MODE,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [PTR_W-1:0]  ref_offset,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W:0]   out_data,
    output logic              baseline_flag,
    output logic [15:0]       sat_count
);

    logic [DATA_W-1:0] sat_q;
    gsm_e              mode_q;
    logic [WIN_W-1:0]  win_q;
    logic              first_q;
    logic [PTR_W-1:0]  l_q, wr_ptr_q, fill_q;
    logic [WIN_W:0]    cnt_q, cnt_d;
    logic              valid_q, gain_q, gain_d, bmode_q;
    logic [DATA_W-1:0] rd10, rd01;

    logic              wr_en, emit, sat_n;
    logic [PTR_W-1:0]  rd_addr;
    logic [WIN_W:0]    win_eff, win_full;

    assign wr_en   = in_valid && !flush;
    assign emit    = wr_en && (fill_q == l_q);
    assign rd_addr = wr_ptr_q - l_q;
    assign sat_n   = (DATA_gain_10 >= sat_q);

    assign win_eff  = (win_q == '0) ? (WIN_W+1)'(1) : {1'b0, win_q};
    assign win_full = (mode_q == GSM_AUTO2) ? {win_eff[WIN_W-1:0], 1'b0} : win_eff;

    // Counter holds the remaining window length after the last saturation.
    // c_old >= 2 means a saturation within the previous W-1 writes.
    always_comb begin
        cnt_d  = cnt_q;
        gain_d = 1'b0;
        unique case (mode_q)
            GSM_FORCE10: begin
                cnt_d  = '0;
                gain_d = 1'b0;
            end
            GSM_FORCE1: begin
                cnt_d  = '0;
                gain_d = 1'b1;
            end
            GSM_AUTO, GSM_AUTO2: begin
                gain_d = sat_n || (cnt_q >= (WIN_W+1)'(2));
                if (flush) begin
                    cnt_d = '0;
                end else if (wr_en) begin
                    if (sat_n)
                        cnt_d = win_full;
                    else if (cnt_q != '0)
                        cnt_d = cnt_q - (WIN_W+1)'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sat_q    <= SAT_RESET[DATA_W-1:0];
            mode_q   <= GSM_AUTO;
            win_q    <= '0;
            first_q  <= 1'b1;
            l_q      <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            gain_q   <= 1'b0;
            bmode_q  <= 1'b0;
        end else begin
            sat_q   <= SATURATION_value;
            mode_q  <= gsm_e'(GAIN_SEL_MODE);
            win_q   <= win_len;
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            valid_q <= emit;
            if (first_q || flush)
                l_q <= ref_offset;
            if (flush)
                fill_q <= '0;
            else if (wr_en && (fill_q != l_q))
                fill_q <= fill_q + PTR_W'(1);
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            // Baseline test width follows the mode that produced the sample.
            if (emit) begin
                gain_q  <= gain_d;
                bmode_q <= mode_q[1];
            end
        end
    end

    ldtu_lookahead_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .CLK       (CLK),
        .reset     (reset),
        .we_i      (wr_en),
        .waddr_i   (wr_ptr_q),
        .wdata10_i (DATA_gain_10),
        .wdata01_i (DATA_gain_01),
        .re_i      (emit),
        .raddr_i   (rd_addr),
        .rdata10_o (rd10),
        .rdata01_o (rd01)
    );

    assign out_valid     = valid_q;
    assign out_data      = {gain_q, gain_q ? rd01 : rd10};
    assign baseline_flag = bmode_q ? (out_data[DATA_W-1:BASE_BITS] == '0)
                                   : (out_data[DATA_W:BASE_BITS] == '0);

`ifdef GAIN_SEL_STATS_EN
    logic [15:0] sat_cnt_q;

    // Counts saturations that open a fresh window (counter idle).
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            sat_cnt_q <= '0;
        else if (flush)
            sat_cnt_q <= '0;
        else if (wr_en && sat_n && !mode_q[1] && (cnt_q == '0) && (sat_cnt_q != 16'hFFFF))
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_ldtu_gain_select_buffer.sv
module tb_ldtu_gain_select_buffer;

    localparam int DATA_W = 12;
    localparam int PTR_W  = 4;
    localparam int WIN_W  = 6;
`ifdef GAIN_SEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              reset, in_valid, flush;
    logic [DATA_W-1:0] DATA_gain_10, DATA_gain_01, SATURATION_value;
    logic [1:0]        GAIN_SEL_MODE;
    logic [WIN_W-1:0]  win_len;
    logic [PTR_W-1:0]  ref_offset;
    logic              out_valid, baseline_flag;
    logic [DATA_W:0]   out_data;
    logic [15:0]       sat_count;

    always #5 CLK = ~CLK;

    ldtu_gain_select_buffer dut (
        .CLK              (CLK),
        .reset            (reset),
        .in_valid         (in_valid),
        .DATA_gain_10     (DATA_gain_10),
        .DATA_gain_01     (DATA_gain_01),
        .SATURATION_value (SATURATION_value),
        .GAIN_SEL_MODE    (GAIN_SEL_MODE),
        .win_len          (win_len),
        .ref_offset       (ref_offset),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .baseline_flag    (baseline_flag),
        .sat_count        (sat_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: full history of accepted samples since the last
    // flush/reset; gain and statistics come from looking back over it.
    typedef struct {
        int d10;
        int d01;
        bit opens;   // saturation seen while in an auto mode
    } smp_t;
    smp_t hist[$];
    int   m_sat, m_mode, m_win, m_L, m_satcnt;
    bit   m_first;
    bit              obs_v;
    logic [DATA_W:0] obs_d;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] sat;
        logic [11:0] d10;
        logic [11:0] d01;
        logic [12:0] exp_d;
        logic        exp_bl;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_sat = 4095; m_mode = 0; m_win = 0; m_L = 0; m_satcnt = 0; m_first = 1'b1;
    endtask

    // One clock: drive, update model, check everything the DUT shows.
    task automatic cycle(input bit iv, input bit fl, input int d10, input int d01);
        bit ev, ebl, s, auto_m, rec, anyw;
        int ed, g, k, n, w;
        in_valid = iv; flush = fl;
        DATA_gain_10 = 12'(d10); DATA_gain_01 = 12'(d01);
        @(posedge CLK);
        ev = 0; ebl = 0; ed = 0;
        if (fl) begin
            hist.delete();
            m_satcnt = 0;
        end else if (iv) begin
            s      = (d10 >= m_sat);
            auto_m = (m_mode < 2);
            w      = ((m_win == 0) ? 1 : m_win) * ((m_mode == 1) ? 2 : 1);
            n      = hist.size();
            rec = 0; anyw = 0;
            for (int j = n - 1; j >= 0 && j >= n - w; j--) begin
                if (hist[j].opens) begin
                    anyw = 1;
                    if (j >= n - w + 1) rec = 1;
                end
            end
            if (auto_m && s && !anyw && m_satcnt < 65535) m_satcnt++;
            hist.push_back('{d10, d01, s && auto_m});
            if (n >= m_L) begin
                ev  = 1;
                k   = n - m_L;
                g   = (m_mode == 2) ? 0 : (m_mode == 3) ? 1 : ((s || rec) ? 1 : 0);
                ed  = g * 4096 + (g ? hist[k].d01 : hist[k].d10);
                ebl = (m_mode < 2) ? (ed < 64) : ((ed % 4096) < 64);
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            chk("out_data", 32'(out_data), ed);
            chk("baseline_flag", 32'(baseline_flag), 32'(ebl));
        end
        chk("sat_count", 32'(sat_count), STATS ? m_satcnt : 0);
        obs_v = out_valid;
        obs_d = out_data;
        m_sat  = int'(SATURATION_value);
        m_mode = int'(GAIN_SEL_MODE);
        m_win  = int'(win_len);
        if (m_first || fl) m_L = int'(ref_offset);
        m_first = 1'b0;
    endtask

    task automatic reconfig(input int mode, input int sat, input int win, input int l);
        GAIN_SEL_MODE = 2'(mode); SATURATION_value = 12'(sat);
        win_len = 6'(win); ref_offset = 4'(l);
        cycle(0, 1, 0, 0);
    endtask

    initial begin
        int gain_obs[32];
        int first_n, seq, exp_next, silent, d10;

        tbl[0]  = '{2'd3, 12'hFFF, 12'h000, 12'h040, 13'h1040, 1'b0};
        tbl[1]  = '{2'd3, 12'hFFF, 12'h000, 12'h03F, 13'h103F, 1'b1};
        tbl[2]  = '{2'd2, 12'hFFF, 12'hFFF, 12'h000, 13'h0FFF, 1'b0};
        tbl[3]  = '{2'd2, 12'hFFF, 12'h03F, 12'h7FF, 13'h003F, 1'b1};
        tbl[4]  = '{2'd0, 12'hFFF, 12'h03F, 12'h000, 13'h003F, 1'b1};
        tbl[5]  = '{2'd0, 12'hFFF, 12'h040, 12'h000, 13'h0040, 1'b0};
        tbl[6]  = '{2'd0, 12'hFFF, 12'hFFF, 12'h020, 13'h1020, 1'b0};
        tbl[7]  = '{2'd0, 12'hFFF, 12'hFFE, 12'h021, 13'h0FFE, 1'b0};
        tbl[8]  = '{2'd0, 12'hFFF, 12'h000, 12'hFFF, 13'h0000, 1'b1};
        tbl[9]  = '{2'd1, 12'h800, 12'h800, 12'h010, 13'h1010, 1'b0};
        tbl[10] = '{2'd1, 12'h800, 12'h7FF, 12'h011, 13'h1011, 1'b0};
        tbl[11] = '{2'd1, 12'h800, 12'h000, 12'h012, 13'h0000, 1'b1};
        tbl[12] = '{2'd3, 12'h800, 12'h000, 12'h000, 13'h1000, 1'b1};

        // Reset state, then ramp with L=3
        reset = 1'b1; in_valid = 0; flush = 0; DATA_gain_10 = 0; DATA_gain_01 = 0;
        SATURATION_value = 12'hFFF; GAIN_SEL_MODE = 2'd0; win_len = 0; ref_offset = 4'd3;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_baseline", 32'(baseline_flag), 1);
        chk("rst_sat_count", 32'(sat_count), 0);
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        first_n = -1;
        for (int n = 0; n <= 20; n++) begin
            cycle(1, 0, n, n);
            if (obs_v && first_n < 0) first_n = n;
        end
        chk("first_emit_index", first_n, 3);

        // Forced/auto single-sample vectors with zero look-ahead
        reconfig(0, 12'hFFF, 0, 0);
        for (int i = 0; i < 13; i++) begin
            GAIN_SEL_MODE = tbl[i].mode;
            SATURATION_value = tbl[i].sat;
            cycle(0, 0, 0, 0);
            cycle(1, 0, tbl[i].d10, tbl[i].d01);
            chk("tbl_data", 32'(obs_d), 32'(tbl[i].exp_d));
            chk("tbl_baseline", 32'(baseline_flag), 32'(tbl[i].exp_bl));
        end

        // Single saturation at n=10, W=4, L=3: window covers n in 10..13,
        // i.e. emitted samples 7..10.
        reconfig(0, 12'h800, 4, 3);
        for (int i = 0; i < 32; i++) gain_obs[i] = -1;
        for (int n = 0; n <= 15; n++) begin
            cycle(1, 0, (n == 10) ? 12'h900 : n, 12'h100 + n);
            if (obs_v) gain_obs[n - 3] = int'(obs_d[12]);
        end
        for (int k = 4; k <= 12; k++)
            chk("win4_gain", gain_obs[k], (k >= 7 && k <= 10) ? 1 : 0);

        // Same in mode 01: W=8, samples 7..14 use x1
        reconfig(1, 12'h800, 4, 3);
        for (int i = 0; i < 32; i++) gain_obs[i] = -1;
        for (int n = 0; n <= 20; n++) begin
            cycle(1, 0, (n == 10) ? 12'h900 : n, 12'h100 + n);
            if (obs_v) gain_obs[n - 3] = int'(obs_d[12]);
        end
        for (int k = 4; k <= 17; k++)
            chk("win8_gain", gain_obs[k], (k >= 7 && k <= 14) ? 1 : 0);

        // Gapped input, L=14, several pointer wraps, then flush mid-stream
        reconfig(0, 12'hFFF, 0, 14);
        seq = 0; exp_next = 0;
        for (int i = 0; i < 110; i++) begin
            cycle(i % 2 == 0, 0, seq, 0);
            if (i % 2 == 0) seq++;
            if (obs_v) begin
                chk("order", 32'(obs_d), exp_next);
                exp_next++;
            end
        end
        cycle(0, 1, 0, 0);
        exp_next = seq; silent = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(i % 2 == 0, 0, seq, 0);
            if (i % 2 == 0) seq++;
            if (obs_v) begin
                if (i < 28) silent++;
                chk("order_post_flush", 32'(obs_d), exp_next);
                exp_next++;
            end
        end
        chk("post_flush_silent", silent, 0);
        chk("post_flush_emitted", exp_next, seq - 14);

        // Saturation statistics: three fresh windows, one inside an open one
        reconfig(0, 12'h800, 4, 0);
        for (int n = 0; n <= 24; n++) begin
            d10 = (n == 2 || n == 10 || n == 12 || n == 20) ? 12'hA00 : 12'h010;
            cycle(1, 0, d10, n);
        end
        chk("sat_count_final", 32'(sat_count), STATS ? 3 : 0);

        // Randomized segments against the model
        for (int seg = 0; seg < 6; seg++) begin
            reconfig($urandom_range(0, 3), $urandom_range(12'h400, 12'hFFF),
                     $urandom_range(0, 12), $urandom_range(0, 14));
            for (int i = 0; i < 100; i++)
                cycle($urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                      $urandom_range(0, 12'hFFF), $urandom_range(0, 12'hFFF));
        end

        // Reset mid-operation clears outputs without a clock edge
        reconfig(0, 12'hFFF, 0, 2);
        for (int n = 0; n < 5; n++) cycle(1, 0, 100 + n, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_baseline", 32'(baseline_flag), 1);
        chk("midrst_sat_count", 32'(sat_count), 0);
        model_reset();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        for (int n = 0; n < 6; n++) cycle(1, 0, 200 + n, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
